rotary_quadrature_decoder: RTL and testbench
============================================

Name: rotary_quadrature_decoder

Overview:
Decodes one raw two-bit quadrature rotary dial on the display board into a debounced, signed detent position and per-detent step pulses.
- One instance per dial, left and right.
- Sits between the dial input pins and the CPU-visible dial register / PIO.
- Replaces passing raw dial bits to software.
- Detects illegal double-bit transitions and counts them for diagnostics.

Parameters:
DEBOUNCE_CYCLES, 500, consecutive clock cycles a synchronised input must hold a new value before acceptance (10 us at 50 MHz); legal range 1..65535.
COUNT_WIDTH, 8, width of the position counter (two's complement, wraps).
STEPS_PER_DETENT, 4, valid Gray transitions per reported step (legal values 1, 2, 4).

Ports:
clock  input  1  system clock (50 MHz).
reset  input  1  synchronous, active-high reset.
dial_in  input  2  raw asynchronous dial pins; bit0 = A, bit1 = B.
clear  input  1  single-cycle request to zero the position and sub-count.
position  output  COUNT_WIDTH  signed detent count; +1 per clockwise detent.
step_valid  output  1  one-cycle pulse per completed detent.
step_dir  output  1  direction of the last step; 1 = clockwise, held between pulses.
error_pulse  output  1  one-cycle pulse on an illegal transition.
error_count  output  8  saturating count of illegal transitions.

Behaviour:
Reset:
- All outputs go to 0.
- Synchroniser flops, candidate, stable state and debounce counter go to 0.
- sub-count goes to 0.
- `primed` flag is cleared.

Synchroniser:
- Two flops per bit; `s` is the second-stage value.

Debounce:
- Counter `cnt` tracks how long `s` has differed from `stable`.
- If `s == stable`, then `cnt <= 0`.
- Else if `s` differs from the value sampled last cycle, then `cnt <= 0` (restart).
- Else `cnt` increments.
- When `cnt == DEBOUNCE_CYCLES-1` and `s != stable`, the next edge performs the accept: `stable <= s` and `cnt <= 0`.

Priming:
- While `primed == 0`, the first accept, or `cnt` reaching terminal with `s == stable`, sets `primed`.
- That first accept loads `stable` with no step and no error.
- This prevents spurious counts from the reset value.

Decode (evaluated on each primed accept, old = `stable`, new = `s`):
- Clockwise order: 00 -> 01 -> 11 -> 10 -> 00.
- A move forward in that order is +1.
- A move backward is -1.
- A change of both bits is illegal: `error_pulse = 1`, `error_count` increments and saturates at 255, sub-count resets to 0, position is unchanged.

Sub-count:
- Signed, range -(STEPS_PER_DETENT-1)..+(STEPS_PER_DETENT-1).
- Adding +1 when sub-count is STEPS_PER_DETENT-1: sub-count goes to 0, position +1, `step_valid = 1`, `step_dir = 1`.
- Adding -1 when sub-count is -(STEPS_PER_DETENT-1): sub-count goes to 0, position -1, `step_valid = 1`, `step_dir = 0`.
- Any other legal move only changes the sub-count, so a reversal mid-detent cancels the partial count.

Arithmetic:
- `position` wraps modulo 2^COUNT_WIDTH: 127 + 1 = -128 for width 8.

Timing:
- `stable`, `position`, `step_valid`, `step_dir` and `error_pulse` all update on the same accept edge.
- Latency from the first edge at which `s` shows the new value to the `step_valid` high cycle is exactly DEBOUNCE_CYCLES + 1 edges.
- Add 2 edges for the synchroniser when measuring from `dial_in`.

Clear:
- `position <= 0` and sub-count `<= 0`.
- Clear has priority over a simultaneous step: `step_valid` is suppressed, `step_dir` is unchanged, and `stable` still updates.
- Clear does not affect `error_count` or priming.

Reset mid-operation:
- Returns every register to reset values on the next edge.
- The next accept is a priming accept.

Bounce:
- Any glitch shorter than DEBOUNCE_CYCLES cycles produces no output change.

Test Plan:
Test parameters: DEBOUNCE_CYCLES = 4, COUNT_WIDTH = 8, STEPS_PER_DETENT = 4.
- Reset, hold `dial_in` = 10 for 20 cycles -> priming only; `position` = 0, no `step_valid`, no `error_pulse`.
- From primed 00, drive 01, 11, 10, 00 with each held 10 cycles -> exactly one `step_valid` pulse, on the 00 accept; `position` = 1; `step_dir` = 1.
- Same sequence reversed, three times -> `position` = -3 (8'hFD); three pulses with `step_dir` = 0. Separately, 00 -> 01 -> 00 -> no step.
- Direct jump 00 -> 11 held 10 cycles -> one `error_pulse`, `error_count` = 1, `position` unchanged. Repeat 300 times -> `error_count` = 255.
- 1-, 2- and 3-cycle glitches on A between full detents -> no change to any output. Verify step latency is exactly 5 edges after `s` changes.
- Preload to 127 via clockwise detents, then one more detent -> `position` = -128. Assert `clear` on the accept cycle of a detent -> `position` = 0 and no `step_valid`.

Source files
------------

// File: rtl/rotary_quadrature_decoder_if.sv
// Dial-side bus of one rotary quadrature decoder: raw pins and clear in, position/step/error out.
interface rotary_quadrature_decoder_if #(
  parameter int COUNT_WIDTH = 8
);
  logic [1:0]             dial_in;
  logic                   clear;
  logic [COUNT_WIDTH-1:0] position;
  logic                   step_valid;
  logic                   step_dir;
  logic                   error_pulse;
  logic [7:0]             error_count;

  modport master (
    output dial_in, clear,
    input  position, step_valid, step_dir, error_pulse, error_count
  );

  modport slave (
    input  dial_in, clear,
    output position, step_valid, step_dir, error_pulse, error_count
  );
endinterface

// File: rtl/rotary_quadrature_decoder.sv
// Debounced quadrature dial decoder: signed detent position, per-detent step pulses, illegal-move count.
// Latency: step_valid rises DEBOUNCE_CYCLES+1 edges after the synchronised input changes; no backpressure.
module rotary_quadrature_decoder #(
  parameter int DEBOUNCE_CYCLES  = 500,
  parameter int COUNT_WIDTH      = 8,
  parameter int STEPS_PER_DETENT = 4
) (
  input logic                         clock,
  input logic                         reset,
  rotary_quadrature_decoder_if.slave  dial
);
  localparam logic [15:0]            CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic signed [3:0]      SUB_MAX  = 4'(STEPS_PER_DETENT - 1);
  localparam logic signed [3:0]      SUB_MIN  = 4'(1 - STEPS_PER_DETENT);
  localparam logic [COUNT_WIDTH-1:0] POS_ONE  = COUNT_WIDTH'(1);

  logic [1:0]             sync1;
  logic [1:0]             s;
  logic [1:0]             s_prev;
  logic [1:0]             stable;
  logic [15:0]            cnt;
  logic                   primed;
  logic signed [3:0]      sub;
  logic [COUNT_WIDTH-1:0] position_q;
  logic                   step_valid_q;
  logic                   step_dir_q;
  logic                   error_pulse_q;
  logic [7:0]             error_count_q;

  logic       steady;
  logic       terminal;
  logic       accept;
  logic [1:0] move;
  logic       fwd;
  logic       bwd;
  logic       illegal;

  // Position of a Gray code along the clockwise cycle 00 -> 01 -> 11 -> 10.
  function automatic logic [1:0] gray_idx(input logic [1:0] g);
    case (g)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  always_comb begin
    steady   = (s == s_prev);
    terminal = steady && (cnt == CNT_LAST);
    accept   = terminal && (s != stable);
    move     = gray_idx(s) - gray_idx(stable);
    fwd      = (move == 2'd1);
    bwd      = (move == 2'd3);
    illegal  = (move == 2'd2);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1         <= '0;
      s             <= '0;
      s_prev        <= '0;
      stable        <= '0;
      cnt           <= '0;
      primed        <= 1'b0;
      sub           <= '0;
      position_q    <= '0;
      step_valid_q  <= 1'b0;
      step_dir_q    <= 1'b0;
      error_pulse_q <= 1'b0;
      error_count_q <= '0;
    end else begin
      step_valid_q  <= 1'b0;
      error_pulse_q <= 1'b0;
      sync1         <= dial.dial_in;
      s             <= sync1;
      s_prev        <= s;

      // Before priming the counter also runs while s matches the reset value,
      // so a dial resting at 00 still primes.
      if (!steady || (primed && s == stable) || terminal)
        cnt <= '0;
      else
        cnt <= cnt + 16'd1;

      if (terminal && !primed) begin
        primed <= 1'b1;
        stable <= s;
      end else if (accept) begin
        stable <= s;
        if (illegal) begin
          error_pulse_q <= 1'b1;
          sub           <= '0;
          if (error_count_q != 8'hFF)
            error_count_q <= error_count_q + 8'd1;
        end else if (!dial.clear) begin
          if (fwd) begin
            if (sub == SUB_MAX) begin
              sub          <= '0;
              position_q   <= position_q + POS_ONE;
              step_valid_q <= 1'b1;
              step_dir_q   <= 1'b1;
            end else begin
              sub <= sub + 4'sd1;
            end
          end else if (bwd) begin
            if (sub == SUB_MIN) begin
              sub          <= '0;
              position_q   <= position_q - POS_ONE;
              step_valid_q <= 1'b1;
              step_dir_q   <= 1'b0;
            end else begin
              sub <= sub - 4'sd1;
            end
          end
        end
      end

      if (dial.clear) begin
        position_q <= '0;
        sub        <= '0;
      end
    end
  end

  assign dial.position    = position_q;
  assign dial.step_valid  = step_valid_q;
  assign dial.step_dir    = step_dir_q;
  assign dial.error_pulse = error_pulse_q;
  assign dial.error_count = error_count_q;
endmodule

// File: tb/tb_rotary_quadrature_decoder.sv
// Scoreboard bench for rotary_quadrature_decoder: transaction model queues expected pulses,
// a negedge monitor pops and compares them whenever step_valid or error_pulse fires.
module tb_rotary_quadrature_decoder;
  localparam int D   = 4;
  localparam int SPD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rotary_quadrature_decoder_if #(.COUNT_WIDTH(8)) bus ();

  rotary_quadrature_decoder #(
    .DEBOUNCE_CYCLES (D),
    .COUNT_WIDTH     (8),
    .STEPS_PER_DETENT(SPD)
  ) dut (
    .clock (clk),
    .reset (rst),
    .dial  (bus)
  );

  typedef struct packed {
    logic       is_err;
    logic       dir;
    logic [7:0] pos;
    logic [7:0] errc;
  } ev_t;

  ev_t        exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [1:0] cw_order[4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  logic [1:0] m_stable;
  int         m_sub;
  logic [7:0] m_pos;
  logic [7:0] m_err;
  logic       m_dir;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int pos_of(input logic [1:0] g);
    for (int i = 0; i < 4; i++)
      if (cw_order[i] == g) return i;
    return 0;
  endfunction

  // Transaction-level model of one accepted dial value.
  task automatic model_accept(input logic [1:0] v, input bit clr);
    int  d;
    bit  push;
    ev_t e;
    d    = (pos_of(v) - pos_of(m_stable) + 4) % 4;
    push = 1'b0;
    e    = '0;
    if (d == 2) begin
      if (m_err != 8'd255) m_err = m_err + 8'd1;
      m_sub    = 0;
      e.is_err = 1'b1;
      push     = 1'b1;
    end else if (d == 1) begin
      if (m_sub == SPD - 1 && !clr) begin
        m_sub = 0; m_pos = m_pos + 8'd1; m_dir = 1'b1; push = 1'b1;
      end else m_sub++;
    end else if (d == 3) begin
      if (m_sub == -(SPD - 1) && !clr) begin
        m_sub = 0; m_pos = m_pos - 8'd1; m_dir = 1'b0; push = 1'b1;
      end else m_sub--;
    end
    if (clr) begin
      m_pos = '0;
      m_sub = 0;
    end
    m_stable = v;
    if (push) begin
      e.dir  = m_dir;
      e.pos  = m_pos;
      e.errc = m_err;
      exp_q.push_back(e);
    end
  endtask

  // Drive a new dial value long enough to be accepted; optionally pulse clear on the accept edge.
  task automatic move(input logic [1:0] v, input bit clr_at_accept);
    model_accept(v, clr_at_accept);
    bus.dial_in = v;
    if (clr_at_accept) begin
      tick(6);
      bus.clear = 1'b1;
      tick(1);
      bus.clear = 1'b0;
      tick(3);
    end else begin
      tick(10);
    end
  endtask

  task automatic detent(input bit cw, input bit clr_last);
    for (int k = 0; k < 4; k++)
      move(cw_order[(pos_of(m_stable) + (cw ? 1 : 3)) % 4], clr_last && (k == 3));
  endtask

  task automatic do_reset(input logic [1:0] v);
    bus.dial_in = v;
    bus.clear   = 1'b0;
    rst         = 1'b1;
    tick(3);
    chk("rst_position",    32'(bus.position),    32'd0);
    chk("rst_step_valid",  32'(bus.step_valid),  32'd0);
    chk("rst_step_dir",    32'(bus.step_dir),    32'd0);
    chk("rst_error_pulse", 32'(bus.error_pulse), 32'd0);
    chk("rst_error_count", 32'(bus.error_count), 32'd0);
    exp_q.delete();
    rst = 1'b0;
    tick(20);
    m_stable = v;
    m_sub    = 0;
    m_pos    = '0;
    m_err    = '0;
    m_dir    = 1'b0;
  endtask

  task automatic glitch_a(input int n);
    bus.dial_in = m_stable ^ 2'b01;
    tick(n);
    bus.dial_in = m_stable;
    tick(10);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_position"},    32'(bus.position),    32'(m_pos));
    chk({tag, "_step_dir"},    32'(bus.step_dir),    32'(m_dir));
    chk({tag, "_error_count"}, 32'(bus.error_count), 32'(m_err));
    chk({tag, "_pending"},     32'(exp_q.size()),    32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && (bus.step_valid || bus.error_pulse)) begin
      if (exp_q.size() == 0) begin
        chk("spurious_pulse", 32'({bus.step_valid, bus.error_pulse}), 32'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("pulse_kind",  32'({bus.step_valid, bus.error_pulse}), e.is_err ? 32'd1 : 32'd2);
        chk("pulse_dir",   32'(bus.step_dir),    32'(e.dir));
        chk("pulse_pos",   32'(bus.position),    32'(e.pos));
        chk("pulse_errc",  32'(bus.error_count), 32'(e.errc));
      end
    end
  end

  initial begin
    int lat;
    bus.dial_in = 2'b00;
    bus.clear   = 1'b0;

    // Priming at a non-zero rest value produces nothing.
    do_reset(2'b10);
    check_idle("prime10");

    // One clockwise detent from 00.
    do_reset(2'b00);
    detent(1'b1, 1'b0);
    check_idle("cw1");
    chk("cw1_pos_is_1", 32'(bus.position), 32'd1);

    // Idle clear, then three counter-clockwise detents.
    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
    m_pos = '0;
    m_sub = 0;
    tick(2);
    chk("clear_idle_pos", 32'(bus.position), 32'd0);
    for (int i = 0; i < 3; i++) detent(1'b0, 1'b0);
    chk("ccw3_pos_fd", 32'(bus.position), 32'hFD);
    move(2'b01, 1'b0);
    move(2'b00, 1'b0);
    check_idle("reversal");

    // Short glitches on A are absorbed.
    for (int n = 1; n <= 3; n++) glitch_a(n);
    check_idle("glitch");

    // Step latency from dial_in: 2 sync edges + DEBOUNCE_CYCLES + 1.
    move(2'b01, 1'b0);
    move(2'b11, 1'b0);
    move(2'b10, 1'b0);
    model_accept(2'b00, 1'b0);
    bus.dial_in = 2'b00;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      if (bus.step_valid) begin
        lat = i;
        break;
      end
    end
    chk("step_latency", 32'(lat), 32'(D + 3));
    tick(5);
    check_idle("latency");

    // Illegal double-bit jumps, saturating at 255.
    for (int i = 0; i < 300; i++) move(m_stable ^ 2'b11, 1'b0);
    chk("err_saturated", 32'(bus.error_count), 32'd255);
    check_idle("errors");

    // Reset mid-operation; the next accept only primes.
    do_reset(2'b10);
    check_idle("rst_mid");

    // Wrap 127 -> -128.
    for (int i = 0; i < 127; i++) detent(1'b1, 1'b0);
    chk("pos_127", 32'(bus.position), 32'd127);
    detent(1'b1, 1'b0);
    chk("pos_wrap", 32'(bus.position), 32'h80);

    // Clear on the completing accept suppresses the step.
    detent(1'b1, 1'b1);
    check_idle("clear_accept");
    chk("clear_accept_pos", 32'(bus.position), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
